// File: rtl/ssd_pkg.sv
// Shared constants for the BCD scan display: segment codes, slot encoding, widths.
package ssd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 8;
  localparam int unsigned AN_W  = 4;

  // Active-low segment codes, bit 0 = a ... bit 6 = g, bit 7 = dp (kept off).
  localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'hBF;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Active-low anode patterns.
  localparam logic [AN_W-1:0] AN_OFF  = 4'b1111;
  localparam logic [AN_W-1:0] AN_ONES = 4'b1110;
  localparam logic [AN_W-1:0] AN_TENS = 4'b1101;

  typedef enum logic {
    SLOT_ONES = 1'b0,
    SLOT_TENS = 1'b1
  } slot_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import ssd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg_c
);

  // Digit lookup with dash fallback for non-BCD codes
  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Two-digit multiplexed 7-segment driver with frame-synchronous digit latch,
// anti-ghost guard, leading-zero blanking and flash-at-zero.
module bcd_scan_display
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 500,
  parameter int unsigned FLASH_FRAMES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic       blank_lz,
  input  logic       flash_en,
  output logic [3:0] ssd_an,
  output logic [7:0] ssd_seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(FLASH_FRAMES - 1);

  slot_e             slot_q, slot_d;
  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              flash_phase_q, flash_phase_d;
  logic [BCD_W-1:0]  d0_q, d0_d;
  logic [BCD_W-1:0]  d1_q, d1_d;
  logic [AN_W-1:0]   an_q, an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;

  logic              frame_start_c;
  logic [BCD_W-1:0]  cur_digit_c;
  logic [SEG_W-1:0]  dec_seg_c;
  logic              guard_c;
  logic              lz_blank_c;
  logic              flash_blank_c;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= SLOT_ONES;
      scan_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
      d0_q          <= '0;
      d1_q          <= '0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
    end else begin
      slot_q        <= slot_d;
      scan_cnt_q    <= scan_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      flash_phase_q <= flash_phase_d;
      d0_q          <= d0_d;
      d1_q          <= d1_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  // Scan counter and slot FSM: slot toggles only on counter wrap
  always_comb begin
    slot_d     = slot_q;
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      case (slot_q)
        SLOT_ONES: slot_d = SLOT_TENS;
        SLOT_TENS: slot_d = SLOT_ONES;
        default:   slot_d = SLOT_ONES;
      endcase
    end
  end

  assign frame_start_c = (slot_q == SLOT_ONES) && (scan_cnt_q == '0);

  // Both digits are captured together at frame start so a frame never tears
  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    if (frame_start_c) begin
      d0_d = digit0;
      d1_d = digit1;
    end
  end

  // Flash half-period counter, held cleared unless 00 is latched and flashing is on
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    flash_phase_d = flash_phase_q;
    if (!flash_en || (d1_q != '0) || (d0_q != '0)) begin
      frame_cnt_d   = '0;
      flash_phase_d = 1'b0;
    end else if (frame_start_c) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end
  end

  // Decode uses the values that belong to the current frame, including its first cycle
  assign cur_digit_c = (slot_q == SLOT_ONES) ? d0_d : d1_d;

  bcd_to_seg7 u_dec (
    .bcd   (cur_digit_c),
    .seg_c (dec_seg_c)
  );

  // Anode/segment selection, registered one cycle after the scan state
  always_comb begin
    an_d          = AN_OFF;
    seg_d         = SEG_BLANK;
    guard_c       = 32'(scan_cnt_q) < GUARD;
    lz_blank_c    = (slot_q == SLOT_TENS) && blank_lz && (d1_d == '0);
    flash_blank_c = flash_en && (d1_d == '0) && (d0_d == '0) && flash_phase_d;
    if (!(guard_c || lz_blank_c || flash_blank_c)) begin
      an_d  = (slot_q == SLOT_ONES) ? AN_ONES : AN_TENS;
      seg_d = dec_seg_c;
    end
  end

  assign ssd_an  = an_q;
  assign ssd_seg = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with SCAN_DIV=4, GUARD=1, FLASH_FRAMES=2.
module tb_bcd_scan_display;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic       blank_lz;
  logic       flash_en;
  logic [3:0] ssd_an;
  logic [7:0] ssd_seg;

  int checks;
  int errors;

  localparam logic [3:0] OFF_AN  = 4'b1111;
  localparam logic [7:0] OFF_SEG = 8'hFF;

  bcd_scan_display #(
    .SCAN_DIV     (4),
    .GUARD        (1),
    .FLASH_FRAMES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digit0   (digit0),
    .digit1   (digit1),
    .blank_lz (blank_lz),
    .flash_en (flash_en),
    .ssd_an   (ssd_an),
    .ssd_seg  (ssd_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] an_exp, input logic [7:0] seg_exp);
    checks++;
    assert (ssd_an === an_exp) else begin
      errors++;
      $error("FAIL %s ssd_an got %b want %b", tag, ssd_an, an_exp);
    end
    checks++;
    assert (ssd_seg === seg_exp) else begin
      errors++;
      $error("FAIL %s ssd_seg got %h want %h", tag, ssd_seg, seg_exp);
    end
  endtask

  // Steps through n cycles of an 8-cycle frame starting at the ONES guard cycle.
  // After step chg_idx, digit0 is changed to chg_d0 (chg_idx < 0 disables).
  task automatic frame(input string tag,
                       input logic [3:0] oa, input logic [7:0] os,
                       input logic [3:0] ta, input logic [7:0] ts,
                       input int n, input int chg_idx, input logic [3:0] chg_d0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0 || i == 4)
        check($sformatf("%s[%0d]", tag, i), OFF_AN, OFF_SEG);
      else if (i < 4)
        check($sformatf("%s[%0d]", tag, i), oa, os);
      else
        check($sformatf("%s[%0d]", tag, i), ta, ts);
      if (i == chg_idx) digit0 = chg_d0;
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    digit0   = 4'd0;
    digit1   = 4'd3;
    blank_lz = 1'b0;
    flash_en = 1'b0;

    // 1. Reset and basic scan of "30"
    repeat (3) @(negedge clk);
    check("reset", OFF_AN, OFF_SEG);
    rst_n = 1'b1;
    frame("scan30_a", 4'b1110, 8'hC0, 4'b1101, 8'hB0, 8, -1, 4'd0);
    frame("scan30_b", 4'b1110, 8'hC0, 4'b1101, 8'hB0, 8, -1, 4'd0);

    // 2. Mid-frame digit change is deferred to the next frame
    digit1 = 4'd1;
    digit0 = 4'd9;
    frame("tear_9", 4'b1110, 8'h90, 4'b1101, 8'hF9, 8, 2, 4'd8);
    frame("tear_8", 4'b1110, 8'h80, 4'b1101, 8'hF9, 8, -1, 4'd0);

    // 3. Leading-zero blanking, then disabled
    digit1   = 4'd0;
    digit0   = 4'd5;
    blank_lz = 1'b1;
    frame("lz_on", 4'b1110, 8'h92, OFF_AN, OFF_SEG, 8, -1, 4'd0);
    blank_lz = 1'b0;
    frame("lz_off", 4'b1110, 8'h92, 4'b1101, 8'hC0, 8, -1, 4'd0);

    // 4. Flash at 00: two frames on, two off, repeating
    digit0   = 4'd0;
    flash_en = 1'b1;
    frame("fl_on0", 4'b1110, 8'hC0, 4'b1101, 8'hC0, 8, -1, 4'd0);
    frame("fl_on1", 4'b1110, 8'hC0, 4'b1101, 8'hC0, 8, -1, 4'd0);
    frame("fl_off0", OFF_AN, OFF_SEG, OFF_AN, OFF_SEG, 8, -1, 4'd0);
    frame("fl_off1", OFF_AN, OFF_SEG, OFF_AN, OFF_SEG, 8, -1, 4'd0);
    frame("fl_on2", 4'b1110, 8'hC0, 4'b1101, 8'hC0, 8, -1, 4'd0);
    frame("fl_on3", 4'b1110, 8'hC0, 4'b1101, 8'hC0, 8, -1, 4'd0);
    flash_en = 1'b0;
    frame("steady0", 4'b1110, 8'hC0, 4'b1101, 8'hC0, 8, -1, 4'd0);
    frame("steady1", 4'b1110, 8'hC0, 4'b1101, 8'hC0, 8, -1, 4'd0);

    // 5. Invalid BCD code shows a dash
    digit1 = 4'd2;
    digit0 = 4'hB;
    frame("dash", 4'b1110, 8'hBF, 4'b1101, 8'hA4, 8, -1, 4'd0);

    // 6. Asynchronous reset in the middle of the TENS slot
    frame("pre_rst", 4'b1110, 8'hBF, 4'b1101, 8'hA4, 6, -1, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", OFF_AN, OFF_SEG);
    @(posedge clk);
    @(negedge clk);
    check("rst_held", OFF_AN, OFF_SEG);
    rst_n = 1'b1;
    frame("post_rst", 4'b1110, 8'hBF, 4'b1101, 8'hA4, 8, -1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
